// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared types and constants for the instruction fetch stage
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_HOLD = 2'd2,
    ST_DROP = 2'd3
  } fetch_state_t;

  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  function automatic logic [5:0] get_opcode(input logic [31:0] instr);
    return instr[31:26];
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - memory, decode and resolve signals of the fetch stage
interface fetch_unit_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc4;
  logic [5:0]  opcode;

  logic        resolve_valid;
  logic        branch_eq;
  logic        branch_ne;
  logic        jump;
  logic        alu_zero;
  logic [31:0] resolve_pc4;
  logic [15:0] imm16;
  logic [25:0] jtarget;

  modport master (
    output imem_req, imem_addr, if_valid, if_instr, if_pc4, opcode,
    input  imem_ack, imem_rdata, if_ready,
    input  resolve_valid, branch_eq, branch_ne, jump, alu_zero,
    input  resolve_pc4, imm16, jtarget
  );

  modport slave (
    input  imem_req, imem_addr, if_valid, if_instr, if_pc4, opcode,
    output imem_ack, imem_rdata, if_ready,
    output resolve_valid, branch_eq, branch_ne, jump, alu_zero,
    output resolve_pc4, imm16, jtarget
  );

endinterface

// File: rtl/fetch_unit_next_pc_calc.sv
// rtl/fetch_unit_next_pc_calc.sv - redirect decision and target address from resolve inputs
module next_pc_calc (
  input  logic        i_resolve_valid,
  input  logic        i_branch_eq,
  input  logic        i_branch_ne,
  input  logic        i_jump,
  input  logic        i_alu_zero,
  input  logic [31:0] i_resolve_pc4,
  input  logic [15:0] i_imm16,
  input  logic [25:0] i_jtarget,
  output logic        o_redir,
  output logic [31:0] o_target
);

  logic        w_taken;
  logic [31:0] w_br_off;

  assign w_taken  = i_jump | (i_branch_eq & i_alu_zero) | (i_branch_ne & ~i_alu_zero);
  assign w_br_off = {{14{i_imm16[15]}}, i_imm16, 2'b00};

  assign o_redir  = i_resolve_valid & w_taken;
  // jump wins over any branch control raised alongside it
  assign o_target = i_jump ? {i_resolve_pc4[31:28], i_jtarget, 2'b00}
                           : i_resolve_pc4 + w_br_off;

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch FSM with single-entry buffer and redirect handling
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst,
  fetch_unit_if.master  bus
);

  fetch_state_t r_state;
  fetch_state_t w_state_next;
  logic [31:0]  r_pc;
  logic [31:0]  w_pc_next;
  logic [31:0]  r_stale_addr;
  logic [31:0]  w_stale_next;
  logic [31:0]  r_instr;
  logic [31:0]  r_pc4;
  logic         w_load_buf;
  logic         w_clear_buf;
  logic         w_redir;
  logic [31:0]  w_target;

  next_pc_calc u_next_pc_calc (
    .i_resolve_valid (bus.resolve_valid),
    .i_branch_eq     (bus.branch_eq),
    .i_branch_ne     (bus.branch_ne),
    .i_jump          (bus.jump),
    .i_alu_zero      (bus.alu_zero),
    .i_resolve_pc4   (bus.resolve_pc4),
    .i_imm16         (bus.imm16),
    .i_jtarget       (bus.jtarget),
    .o_redir         (w_redir),
    .o_target        (w_target)
  );

  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_stale_next = r_stale_addr;
    w_load_buf   = 1'b0;
    w_clear_buf  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_state_next = ST_REQ;
        if (w_redir) w_pc_next = w_target;
      end
      ST_REQ: begin
        if (bus.imem_ack) begin
          if (w_redir) begin
            w_pc_next = w_target;
          end else begin
            w_load_buf   = 1'b1;
            w_pc_next    = r_pc + 32'd4;
            w_state_next = ST_HOLD;
          end
        end else if (w_redir) begin
          // request is still outstanding: keep its address on the bus until acked
          w_stale_next = r_pc;
          w_pc_next    = w_target;
          w_state_next = ST_DROP;
        end
      end
      ST_DROP: begin
        if (w_redir) w_pc_next = w_target;
        if (bus.imem_ack) w_state_next = ST_REQ;
      end
      ST_HOLD: begin
        if (w_redir) begin
          w_pc_next    = w_target;
          w_clear_buf  = 1'b1;
          w_state_next = ST_REQ;
        end else if (bus.if_ready) begin
          w_state_next = ST_REQ;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_pc         <= RESET_PC;
      r_stale_addr <= RESET_PC;
    end else begin
      r_state      <= w_state_next;
      r_pc         <= w_pc_next;
      r_stale_addr <= w_stale_next;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_instr <= NOP_WORD;
      r_pc4   <= 32'd0;
    end else if (w_load_buf) begin
      r_instr <= bus.imem_rdata;
      r_pc4   <= r_pc + 32'd4;
    end else if (w_clear_buf) begin
      r_instr <= NOP_WORD;
      r_pc4   <= 32'd0;
    end
  end

  assign bus.imem_req  = (r_state == ST_REQ) || (r_state == ST_DROP);
  assign bus.imem_addr = (r_state == ST_DROP) ? r_stale_addr : r_pc;
  assign bus.if_valid  = (r_state == ST_HOLD);
  assign bus.if_instr  = r_instr;
  assign bus.if_pc4    = r_pc4;
  assign bus.opcode    = get_opcode(r_instr);

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;

  localparam logic [31:0] RPC = 32'h0040_0000;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   mem_lat;
  int   wait_cnt;
  bit   mem_auto;

  fetch_unit_if fif ();

  fetch_unit #(.RESET_PC(RPC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (fif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {a[7:2] ^ 6'h23, a[25:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_resolve();
    fif.resolve_valid = 1'b0;
    fif.branch_eq     = 1'b0;
    fif.branch_ne     = 1'b0;
    fif.jump          = 1'b0;
    fif.alu_zero      = 1'b0;
    fif.resolve_pc4   = 32'd0;
    fif.imm16         = 16'd0;
    fif.jtarget       = 26'd0;
  endtask

  // memory responder: acks after mem_lat waiting cycles of an asserted request
  task automatic mem_drive();
    if (mem_auto) begin
      if (fif.imem_req) begin
        if (wait_cnt >= mem_lat) begin
          fif.imem_ack   = 1'b1;
          fif.imem_rdata = word_at(fif.imem_addr);
          wait_cnt       = 0;
        end else begin
          fif.imem_ack = 1'b0;
          wait_cnt++;
        end
      end else begin
        fif.imem_ack = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #1;
    checks++;
    if (fif.imem_req !== 1'b0 || fif.if_valid !== 1'b0 || fif.imem_addr !== RPC ||
        fif.if_instr !== 32'd0 || fif.if_pc4 !== 32'd0 || fif.opcode !== 6'd0) begin
      errors++;
      $display("FAIL reset_state: req=%b valid=%b addr=%h instr=%h pc4=%h op=%h want 0 0 %h 0 0 0",
               fif.imem_req, fif.if_valid, fif.imem_addr, fif.if_instr, fif.if_pc4, fif.opcode, RPC);
    end
    tick();
    rst = 1'b1;
    #1;
    checks++;
    if (fif.imem_req !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_release: req=%b want 0", fif.imem_req);
    end
    tick();
    checks++;
    if (fif.imem_req !== 1'b1 || fif.imem_addr !== RPC) begin
      errors++;
      $display("FAIL first_req: req=%b addr=%h want 1 %h", fif.imem_req, fif.imem_addr, RPC);
    end
  endtask

  task automatic test_seq_fetch();
    logic [31:0] exp_req;
    logic [31:0] exp_hs;
    int          n;
    exp_req = RPC;
    exp_hs  = RPC;
    n       = 0;
    mem_auto = 1'b1;
    mem_lat  = 0;
    wait_cnt = 0;
    fif.if_ready = 1'b1;
    for (int c = 0; c < 40 && n < 3; c++) begin
      mem_drive();
      if (fif.imem_ack) begin
        checks++;
        if (fif.imem_addr !== exp_req) begin
          errors++;
          $display("FAIL seq_addr: got %h want %h", fif.imem_addr, exp_req);
        end
        exp_req = exp_req + 32'd4;
      end
      if (fif.if_valid) begin
        checks++;
        if (fif.if_pc4 !== exp_hs + 32'd4 || fif.if_instr !== word_at(exp_hs)) begin
          errors++;
          $display("FAIL seq_buf: pc4=%h instr=%h want %h %h",
                   fif.if_pc4, fif.if_instr, exp_hs + 32'd4, word_at(exp_hs));
        end
        checks++;
        if (fif.opcode !== fif.if_instr[31:26] || fif.opcode !== (exp_hs[7:2] ^ 6'h23)) begin
          errors++;
          $display("FAIL seq_opcode: got %h want %h", fif.opcode, exp_hs[7:2] ^ 6'h23);
        end
        exp_hs = exp_hs + 32'd4;
        n++;
      end
      tick();
    end
    checks++;
    if (n != 3) begin
      errors++;
      $display("FAIL seq_count: got %0d handshakes want 3", n);
    end
  endtask

  task automatic test_latency_stall();
    bit got;
    bit bad;
    got = 1'b0;
    bad = 1'b0;
    fif.if_ready = 1'b0;
    mem_lat  = 3;
    wait_cnt = 0;
    for (int c = 0; c < 20 && !got; c++) begin
      mem_drive();
      if (fif.imem_ack) begin
        checks++;
        if (fif.imem_addr !== 32'h0040_000C) begin
          errors++;
          $display("FAIL lat_addr: got %h want 0040000c", fif.imem_addr);
        end
      end
      tick();
      if (fif.if_valid) got = 1'b1;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL lat_valid: if_valid never rose, want 1");
    end
    for (int c = 0; c < 4; c++) begin
      mem_drive();
      if (fif.imem_req !== 1'b0 || fif.if_valid !== 1'b1 || fif.if_instr !== word_at(32'h0040_000C))
        bad = 1'b1;
      tick();
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL stall_hold: req/valid/instr changed while stalled, want 0/1/%h", word_at(32'h0040_000C));
    end
    checks++;
    if (fif.if_pc4 !== 32'h0040_0010) begin
      errors++;
      $display("FAIL stall_pc4: got %h want 00400010", fif.if_pc4);
    end
    fif.if_ready = 1'b1;
    mem_lat = 0;
    mem_drive();
    tick();
    fif.if_ready = 1'b0;
    checks++;
    if (fif.imem_req !== 1'b1 || fif.imem_addr !== 32'h0040_0010) begin
      errors++;
      $display("FAIL stall_next_req: req=%b addr=%h want 1 00400010", fif.imem_req, fif.imem_addr);
    end
  endtask

  task automatic test_beq_taken();
    wait_cnt = 0;
    mem_drive();
    tick();
    checks++;
    if (fif.if_valid !== 1'b1) begin
      errors++;
      $display("FAIL beq_pre_valid: got %b want 1", fif.if_valid);
    end
    fif.resolve_valid = 1'b1;
    fif.branch_eq     = 1'b1;
    fif.alu_zero      = 1'b1;
    fif.resolve_pc4   = 32'h0000_0100;
    fif.imm16         = 16'hFFFE;
    mem_drive();
    tick();
    clear_resolve();
    checks++;
    if (fif.if_valid !== 1'b0 || fif.imem_req !== 1'b1 || fif.imem_addr !== 32'h0000_00F8) begin
      errors++;
      $display("FAIL beq_redirect: valid=%b req=%b addr=%h want 0 1 000000f8",
               fif.if_valid, fif.imem_req, fif.imem_addr);
    end
    mem_drive();
    tick();
    checks++;
    if (fif.if_valid !== 1'b1 || fif.if_pc4 !== 32'h0000_00FC || fif.opcode !== 6'h1D) begin
      errors++;
      $display("FAIL beq_target_fetch: valid=%b pc4=%h op=%h want 1 000000fc 1d",
               fif.if_valid, fif.if_pc4, fif.opcode);
    end
  endtask

  task automatic test_redirect_outstanding();
    bit bad;
    bad = 1'b0;
    mem_auto = 1'b0;
    fif.imem_ack = 1'b0;
    fif.if_ready = 1'b1;
    tick();
    fif.if_ready = 1'b0;
    checks++;
    if (fif.imem_req !== 1'b1 || fif.imem_addr !== 32'h0000_00FC) begin
      errors++;
      $display("FAIL jump_pre_req: req=%b addr=%h want 1 000000fc", fif.imem_req, fif.imem_addr);
    end
    fif.resolve_valid = 1'b1;
    fif.jump          = 1'b1;
    fif.branch_eq     = 1'b1;
    fif.alu_zero      = 1'b1;
    fif.imm16         = 16'h0001;
    fif.jtarget       = 26'h000_0040;
    fif.resolve_pc4   = 32'h1000_0010;
    tick();
    clear_resolve();
    for (int c = 0; c < 2; c++) begin
      if (fif.imem_req !== 1'b1 || fif.imem_addr !== 32'h0000_00FC || fif.if_valid !== 1'b0)
        bad = 1'b1;
      if (c == 1) begin
        fif.imem_ack   = 1'b1;
        fif.imem_rdata = 32'hDEAD_BEEF;
      end
      tick();
    end
    fif.imem_ack = 1'b0;
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL drop_hold_addr: stale request not held at 000000fc with if_valid 0");
    end
    checks++;
    if (fif.if_valid !== 1'b0 || fif.imem_req !== 1'b1 || fif.imem_addr !== 32'h1000_0100) begin
      errors++;
      $display("FAIL jump_target_req: valid=%b req=%b addr=%h want 0 1 10000100",
               fif.if_valid, fif.imem_req, fif.imem_addr);
    end
    fif.imem_ack   = 1'b1;
    fif.imem_rdata = word_at(32'h1000_0100);
    tick();
    fif.imem_ack = 1'b0;
    checks++;
    if (fif.if_valid !== 1'b1 || fif.if_pc4 !== 32'h1000_0104 || fif.if_instr !== word_at(32'h1000_0100)) begin
      errors++;
      $display("FAIL jump_fetch: valid=%b pc4=%h instr=%h want 1 10000104 %h",
               fif.if_valid, fif.if_pc4, fif.if_instr, word_at(32'h1000_0100));
    end
  endtask

  task automatic test_no_redirect();
    fif.resolve_valid = 1'b1;
    fif.branch_ne     = 1'b1;
    fif.alu_zero      = 1'b1;
    fif.resolve_pc4   = 32'h0000_0300;
    fif.imm16         = 16'h0010;
    tick();
    clear_resolve();
    fif.resolve_valid = 1'b1;
    tick();
    clear_resolve();
    checks++;
    if (fif.if_valid !== 1'b1 || fif.if_instr !== word_at(32'h1000_0100) || fif.if_pc4 !== 32'h1000_0104) begin
      errors++;
      $display("FAIL nottaken_hold: valid=%b instr=%h pc4=%h want 1 %h 10000104",
               fif.if_valid, fif.if_instr, fif.if_pc4, word_at(32'h1000_0100));
    end
    fif.if_ready = 1'b1;
    tick();
    fif.if_ready = 1'b0;
    fif.resolve_valid = 1'b1;
    fif.branch_ne     = 1'b1;
    fif.alu_zero      = 1'b1;
    fif.imm16         = 16'h0010;
    tick();
    clear_resolve();
    checks++;
    if (fif.imem_req !== 1'b1 || fif.imem_addr !== 32'h1000_0104) begin
      errors++;
      $display("FAIL nottaken_req: req=%b addr=%h want 1 10000104", fif.imem_req, fif.imem_addr);
    end
    fif.imem_ack   = 1'b1;
    fif.imem_rdata = word_at(32'h1000_0104);
    tick();
    fif.imem_ack = 1'b0;
    checks++;
    if (fif.if_valid !== 1'b1 || fif.if_pc4 !== 32'h1000_0108) begin
      errors++;
      $display("FAIL nottaken_seq: valid=%b pc4=%h want 1 10000108", fif.if_valid, fif.if_pc4);
    end
  endtask

  task automatic test_redir_with_ack();
    fif.if_ready = 1'b1;
    tick();
    fif.if_ready = 1'b0;
    fif.imem_ack      = 1'b1;
    fif.imem_rdata    = 32'h1234_5678;
    fif.resolve_valid = 1'b1;
    fif.branch_ne     = 1'b1;
    fif.alu_zero      = 1'b0;
    fif.resolve_pc4   = 32'h0000_0200;
    fif.imm16         = 16'h0004;
    tick();
    fif.imem_ack = 1'b0;
    clear_resolve();
    checks++;
    if (fif.if_valid !== 1'b0 || fif.imem_req !== 1'b1 || fif.imem_addr !== 32'h0000_0210) begin
      errors++;
      $display("FAIL ack_redir: valid=%b req=%b addr=%h want 0 1 00000210",
               fif.if_valid, fif.imem_req, fif.imem_addr);
    end
  endtask

  task automatic test_reset_mid_req();
    rst = 1'b0;
    #1;
    checks++;
    if (fif.imem_req !== 1'b0 || fif.if_valid !== 1'b0 || fif.imem_addr !== RPC) begin
      errors++;
      $display("FAIL async_reset: req=%b valid=%b addr=%h want 0 0 %h",
               fif.imem_req, fif.if_valid, fif.imem_addr, RPC);
    end
    fif.imem_ack   = 1'b1;
    fif.imem_rdata = 32'hBAD0_BAD0;
    tick();
    rst = 1'b1;
    #1;
    checks++;
    if (fif.imem_req !== 1'b0 || fif.if_valid !== 1'b0) begin
      errors++;
      $display("FAIL late_ack_idle: req=%b valid=%b want 0 0", fif.imem_req, fif.if_valid);
    end
    tick();
    fif.imem_ack = 1'b0;
    checks++;
    if (fif.if_valid !== 1'b0 || fif.imem_req !== 1'b1 || fif.imem_addr !== RPC) begin
      errors++;
      $display("FAIL restart_req: valid=%b req=%b addr=%h want 0 1 %h",
               fif.if_valid, fif.imem_req, fif.imem_addr, RPC);
    end
    fif.imem_ack   = 1'b1;
    fif.imem_rdata = word_at(RPC);
    tick();
    fif.imem_ack = 1'b0;
    checks++;
    if (fif.if_valid !== 1'b1 || fif.if_pc4 !== RPC + 32'd4 || fif.if_instr !== word_at(RPC)) begin
      errors++;
      $display("FAIL restart_fetch: valid=%b pc4=%h instr=%h want 1 %h %h",
               fif.if_valid, fif.if_pc4, fif.if_instr, RPC + 32'd4, word_at(RPC));
    end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    mem_auto = 1'b0;
    mem_lat  = 0;
    wait_cnt = 0;
    rst      = 1'b0;
    fif.imem_ack   = 1'b0;
    fif.imem_rdata = 32'd0;
    fif.if_ready   = 1'b0;
    clear_resolve();
    @(negedge clk);
    test_reset();
    test_seq_fetch();
    test_latency_stall();
    test_beq_taken();
    test_redirect_outstanding();
    test_no_redirect();
    test_redir_with_ack();
    test_reset_mid_req();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
